somador_multiciclo: RTL and testbench

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operation CHUNK bits per clock, carrying between chunks in a register. It is the next generation of the team's ripple-carry adder. It adds a configurable width, a subtract mode, signed-overflow detection and a start/busy/done handshake. It is used where a wide add is not needed every cycle and area or timing matters more than throughput.

---
 rtl/somador_pkg.sv | 18 +
 rtl/somador_multiciclo_if.sv | 26 ++
 rtl/somador_chunk.sv | 22 ++
 rtl/somador_multiciclo.sv | 127 ++++++++++++
 tb/tb_somador_multiciclo.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/somador_pkg.sv
// Shared definitions for the multi-cycle adder/subtractor: FSM state
// encoding and the helper that sizes the chunk index counter.
package somador_pkg;

  // Controller states; IDLE is the reset state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the chunk index: clog2(n), never narrower than one bit so the
  // single-chunk configuration still has a legal counter.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/somador_multiciclo_if.sv
// Request/result bundle of the multi-cycle adder. The master drives the
// operation request; the slave (the adder) returns status and result.
interface somador_multiciclo_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/somador_chunk.sv
// Combinational CHUNK-bit adder slice. Besides sum and carry out it exposes
// the carry into its top bit, which the top level uses for signed overflow.
module somador_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] full;

  assign full  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum   = full[CHUNK-1:0];
  assign cout  = full[CHUNK];
  // The top sum bit is a^b^carry_in, so the carry into it falls out directly.
  assign c_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ full[CHUNK-1];

endmodule

// File: rtl/somador_multiciclo.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per clock,
// carry kept in a register between slices, start/busy/done handshake.
module somador_multiciclo
  import somador_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  somador_multiciclo_if.slave  bus
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IW   = idx_width(N);
  localparam int LAST = N - 1;

  // Refuse to elaborate a configuration that cannot be split into slices.
  generate
    if ((WIDTH % CHUNK != 0) || (WIDTH < CHUNK)) begin : g_bad_cfg
      $error("somador_multiciclo: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] ch_a, ch_b, ch_sum;
  logic             ch_cout, ch_c_msb;
  int               lsb;

  // Select the operand slice addressed by the chunk index.
  always_comb begin
    lsb  = int'(idx_q) * CHUNK;
    ch_a = a_q[lsb +: CHUNK];
    ch_b = b_q[lsb +: CHUNK];
  end

  somador_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a     (ch_a),
    .b     (ch_b),
    .cin   (carry_q),
    .sum   (ch_sum),
    .cout  (ch_cout),
    .c_msb (ch_c_msb)
  );

  // Next-state logic: accept in IDLE/DONE, one slice per cycle in RUN.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          // Subtraction is a + ~b + ~borrow, so invert b and the carry-in here.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.cin ^ bus.sub;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[lsb +: CHUNK] = ch_sum;
        carry_d             = ch_cout;
        idx_d               = idx_q + IW'(1);
        if (idx_q == IW'(LAST)) begin
          cout_d  = ch_cout;
          ovf_d   = ch_c_msb ^ ch_cout;
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Status is a decode of the state register only, so busy and done are
  // mutually exclusive and free of input-to-output paths.
  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_somador_multiciclo.sv
// Bench for somador_multiciclo (WIDTH=16, CHUNK=4): directed vectors,
// handshake corner cases, reset behaviour and randomized operations
// checked against an integer-arithmetic reference model.
module tb_somador_multiciclo;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  somador_multiciclo_if #(.WIDTH(16)) bus ();

  somador_multiciclo #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic void model(input logic [15:0] av, input logic [15:0] bv,
                                input logic sv, input logic cv,
                                output logic [15:0] s, output logic co,
                                output logic ov);
    int ua, ub, uc, r, sa, sb, sr;
    ua = int'(av);
    ub = int'(bv);
    uc = cv ? 1 : 0;
    sa = int'($signed(av));
    sb = int'($signed(bv));
    if (!sv) begin
      r  = ua + ub + uc;
      co = (r > 65535);
      sr = sa + sb + uc;
    end else begin
      r  = ua - ub - uc;
      co = (ua >= ub + uc);
      sr = sa - sb - uc;
    end
    s  = r[15:0];
    ov = (sr > 32767) || (sr < -32768);
  endfunction

  // Issue one operation from a falling edge and wait (bounded) for done.
  // Returns at the falling edge where done is high, or after the budget.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                       input logic sv, input logic cv,
                       output int busy_cnt, output bit seen);
    busy_cnt  = 0;
    seen      = 1'b0;
    bus.a     = av;
    bus.b     = bv;
    bus.sub   = sv;
    bus.cin   = cv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int  bc;
    bit  seen;
    bus.start = 1'b0;
    bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.cin = 1'b0;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.cout, bus.ovf, bus.sum} !== 20'h0) begin
      bad++;
      $display("FAIL reset_initial: got busy=%b done=%b cout=%b ovf=%b sum=%h, want all 0",
               bus.busy, bus.done, bus.cout, bus.ovf, bus.sum);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({bus.busy, bus.done} !== 2'b00) begin
        bad++;
        $display("FAIL reset_idle: cycle %0d busy=%b done=%b, want 0 0", i, bus.busy, bus.done);
      end
    end
    // Load a non-zero result, then reset between edges: outputs clear at once.
    do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, bc, seen);
    $display("op reset_setup: 1234+0FFF -> sum=%h seen=%0d", bus.sum, seen);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.cout, bus.ovf, bus.sum} !== 20'h0) begin
      bad++;
      $display("FAIL reset_async: got busy=%b done=%b cout=%b ovf=%b sum=%h, want all 0",
               bus.busy, bus.done, bus.cout, bus.ovf, bus.sum);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  task automatic test_directed();
    vec_t v[7];
    int   bc;
    bit   seen;
    v[0] = '{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0};
    v[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    v[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    v[3] = '{16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0003, 1'b0, 1'b0};
    v[4] = '{16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    v[5] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    v[6] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      do_op(v[i].a, v[i].b, v[i].sub, v[i].cin, bc, seen);
      $display("op directed %0d: a=%h b=%h sub=%b cin=%b -> sum=%h cout=%b ovf=%b busy_cycles=%0d",
               i, v[i].a, v[i].b, v[i].sub, v[i].cin, bus.sum, bus.cout, bus.ovf, bc);
      total++;
      if (!seen) begin
        bad++;
        $display("FAIL directed_%0d_done: no done within budget, want done", i);
        continue;
      end
      total++;
      if (bus.sum !== v[i].sum) begin
        bad++;
        $display("FAIL directed_%0d_sum: got %h, want %h", i, bus.sum, v[i].sum);
      end
      total++;
      if ({bus.cout, bus.ovf} !== {v[i].cout, v[i].ovf}) begin
        bad++;
        $display("FAIL directed_%0d_flags: got cout=%b ovf=%b, want cout=%b ovf=%b",
                 i, bus.cout, bus.ovf, v[i].cout, v[i].ovf);
      end
      total++;
      if (bc != 4 || bus.busy !== 1'b0) begin
        bad++;
        $display("FAIL directed_%0d_timing: got busy_cycles=%0d busy_at_done=%b, want 4 and 0",
                 i, bc, bus.busy);
      end
      @(negedge clk);
      total++;
      if (bus.done !== 1'b0) begin
        bad++;
        $display("FAIL directed_%0d_pulse: done=%b one cycle later, want 0", i, bus.done);
      end
    end
  endtask

  task automatic test_ignore_start();
    bit seen = 1'b0;
    bus.a = 16'h1234; bus.b = 16'h0FFF; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);                       // after E0
    bus.start = 1'b0;
    @(negedge clk);                       // after E1: pulse start across E2
    bus.start = 1'b1;
    bus.a = 16'hAAAA; bus.b = 16'h5555; bus.sub = 1'b1; bus.cin = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    $display("op ignore_start: 1234+0FFF with start at E2 -> sum=%h seen=%0d", bus.sum, seen);
    total++;
    if (!seen || bus.sum !== 16'h2233) begin
      bad++;
      $display("FAIL ignore_start_result: seen=%0d sum=%h, want seen=1 sum=2233", seen, bus.sum);
    end
    @(negedge clk);
    total++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      bad++;
      $display("FAIL ignore_start_queue: busy=%b done=%b after done, want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    int gap;
    bus.a = 16'h0100; bus.b = 16'h0023; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    $display("op b2b_first: 0100+0023 -> sum=%h seen=%0d", bus.sum, seen);
    total++;
    if (!seen || bus.sum !== 16'h0123) begin
      bad++;
      $display("FAIL b2b_first: seen=%0d sum=%h, want seen=1 sum=0123", seen, bus.sum);
    end
    // start still high in DONE: the second request is taken at this cycle's edge.
    bus.a = 16'h0FFF; bus.b = 16'h0001; bus.sub = 1'b1; bus.cin = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_no_idle: busy=%b right after done, want 1", bus.busy);
    end
    gap  = 1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      gap++;
    end
    $display("op b2b_second: 0FFF-0001 -> sum=%h gap=%0d", bus.sum, gap);
    total++;
    if (!seen || gap != 5) begin
      bad++;
      $display("FAIL b2b_gap: seen=%0d gap=%0d cycles, want seen=1 gap=5", seen, gap);
    end
    total++;
    if (bus.sum !== 16'h0FFE || bus.cout !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second: sum=%h cout=%b, want 0FFE 1", bus.sum, bus.cout);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    int bc;
    bus.a = 16'h1234; bus.b = 16'h0FFF; bus.sub = 1'b0; bus.cin = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);                       // after E0
    bus.start = 1'b0;
    @(negedge clk);                       // after E1: reset covers E2
    rst = 1'b1;
    #1;
    total++;
    if ({bus.busy, bus.done, bus.cout, bus.ovf, bus.sum} !== 20'h0) begin
      bad++;
      $display("FAIL reset_mid_clear: busy=%b done=%b cout=%b ovf=%b sum=%h, want all 0",
               bus.busy, bus.done, bus.cout, bus.ovf, bus.sum);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL reset_mid_abort: activity after reset=%0d, want 0", seen);
    end
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0, bc, seen);
    $display("op reset_mid_next: 0001+0002 -> sum=%h seen=%0d", bus.sum, seen);
    total++;
    if (!seen || bus.sum !== 16'h0003 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_next: seen=%0d sum=%h cout=%b ovf=%b, want 1 0003 0 0",
               seen, bus.sum, bus.cout, bus.ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [15:0] av, bv, es;
    logic        sv, cv, eco, eov;
    int          bc;
    bit          seen;
    for (int i = 0; i < 40; i++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      sv = 1'($urandom_range(0, 1));
      cv = 1'($urandom_range(0, 1));
      if (i % 5 == 0) av = 16'h8000 ^ 16'($urandom_range(0, 3));
      model(av, bv, sv, cv, es, eco, eov);
      do_op(av, bv, sv, cv, bc, seen);
      $display("op random %0d: a=%h b=%h sub=%b cin=%b -> sum=%h cout=%b ovf=%b (model %h %b %b)",
               i, av, bv, sv, cv, bus.sum, bus.cout, bus.ovf, es, eco, eov);
      total++;
      if (!seen || bc != 4 || {bus.sum, bus.cout, bus.ovf} !== {es, eco, eov}) begin
        bad++;
        $display("FAIL random_%0d: seen=%0d busy=%0d sum=%h cout=%b ovf=%b, want 1 4 %h %b %b",
                 i, seen, bc, bus.sum, bus.cout, bus.ovf, es, eco, eov);
      end
      // Every other operation starts directly from DONE without an idle cycle.
      if (i % 2 == 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
